// File: rtl/pmod_board_scanner.sv
// Scans a 74HC165-style parallel-in/serial-out chain on the JA header and
// publishes a debounced occupancy word, a sticky valid flag and a change pulse.
module pmod_board_scanner #(
  parameter int N_BITS  = 32,
  parameter int CLK_DIV = 50,
  parameter int STABLE  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_en,
  output logic              sr_load_n,
  output logic              sr_clk,
  input  logic              sr_data,
  output logic [N_BITS-1:0] board,
  output logic              board_valid,
  output logic              changed,
  output logic              busy,
  output logic [15:0]       scan_count
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int SW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CMP} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              phase_q, phase_d;
  logic [N_BITS-1:0] raw_q, raw_d, prev_raw_q, prev_raw_d, board_q, board_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic [15:0]       scan_count_q, scan_count_d;
  logic              load_n_q, load_n_d, sr_clk_q, sr_clk_d;
  logic              valid_q, valid_d, changed_q, changed_d, busy_q, busy_d;
  logic              sync1_q, sync2_q;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    raw_d        = raw_q;
    prev_raw_d   = prev_raw_q;
    board_d      = board_q;
    stable_d     = stable_q;
    scan_count_d = scan_count_q;
    load_n_d     = load_n_q;
    sr_clk_d     = sr_clk_q;
    valid_d      = valid_q;
    changed_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d  = LOAD;
          div_d    = '0;
          load_n_d = 1'b0;
        end
      end
      LOAD: begin
        if (div_q == DIV_LAST) begin
          state_d  = SHIFT;
          div_d    = '0;
          bit_d    = '0;
          phase_d  = 1'b0;
          load_n_d = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // sync2_q lags the pin by two cycles, so this still reads a low-phase value
            raw_d    = {raw_q[N_BITS-2:0], sync2_q};
            phase_d  = 1'b1;
            sr_clk_d = 1'b1;
          end else begin
            phase_d  = 1'b0;
            sr_clk_d = 1'b0;
            if (bit_q == BIT_LAST) state_d = CMP;
            else                   bit_d   = bit_q + BW'(1);
          end
        end
      end
      CMP: begin
        if (raw_q == prev_raw_q)
          stable_d = (stable_q == STB_LAST) ? stable_q : stable_q + SW'(1);
        else
          stable_d = '0;
        prev_raw_d   = raw_q;
        scan_count_d = scan_count_q + 16'd1;
        // an all-zero first result still has to raise board_valid
        if (stable_d == STB_LAST && (raw_q != board_q || !valid_q)) begin
          board_d   = raw_q;
          valid_d   = 1'b1;
          changed_d = (raw_q != board_q);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      raw_q        <= '0;
      prev_raw_q   <= '0;
      board_q      <= '0;
      stable_q     <= '0;
      scan_count_q <= '0;
      load_n_q     <= 1'b1;
      sr_clk_q     <= 1'b0;
      valid_q      <= 1'b0;
      changed_q    <= 1'b0;
      busy_q       <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      raw_q        <= raw_d;
      prev_raw_q   <= prev_raw_d;
      board_q      <= board_d;
      stable_q     <= stable_d;
      scan_count_q <= scan_count_d;
      load_n_q     <= load_n_d;
      sr_clk_q     <= sr_clk_d;
      valid_q      <= valid_d;
      changed_q    <= changed_d;
      busy_q       <= busy_d;
      sync1_q      <= sr_data;
      sync2_q      <= sync1_q;
    end
  end

  always @(posedge clock) begin
    if (reset) assert (CLK_DIV >= 3) else $error("CLK_DIV must be at least 3");
  end

  assign sr_load_n   = load_n_q;
  assign sr_clk      = sr_clk_q;
  assign board       = board_q;
  assign board_valid = valid_q;
  assign changed     = changed_q;
  assign busy        = busy_q;
  assign scan_count  = scan_count_q;
endmodule
